sine_phase_nco: RTL
===================

// Module: sine_phase_nco
// PURPOSE
//  Phase source for the sine generator. Runs in the Clk domain and replaces a
//  derived clock with a one-cycle sample strobe (sample_en).
//  On each strobe it accumulates the CSR frequency control word (fcw).
//  Drives phase/sample_en into sine_wave_generator; run/fcw come from sine_wave_csr.
//  Frequency changes take effect only at phase wrap. Stop completes the current period.
// PARAMETERS
//  DIV      50  Clk cycles per sample_en pulse (50 MHz -> 1 MHz); legal range >= 1
//  FCW_W     8  fcw width
//  ACC_W    16  phase accumulator width; must be >= PHASE_W and >= FCW_W
//  PHASE_W  10  output phase width; phase = acc[ACC_W-1 -: PHASE_W]
// PORTS
//  Clk        in   1        system clock
//  ResetN     in   1        asynchronous active-low reset
//  run        in   1        level; 1 = generate, 0 = stop at next wrap
//  fcw        in   FCW_W    requested frequency control word
//  phase      out  PHASE_W  registered phase; valid and new when sample_en=1
//  sample_en  out  1        one-Clk-cycle strobe, once every DIV cycles while busy
//  wrap       out  1        pulses with sample_en when the accumulator carries out
//  busy       out  1        1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async, ResetN=0): state=IDLE, acc=0, fcw_act=0, tick count=0.
//   Outputs during and after reset: phase=0, sample_en=0, wrap=0, busy=0.
//  Tick: count runs 0..DIV-1 while busy and is held at 0 in IDLE.
//   sample_en is registered and is high in the cycle after count==DIV-1.
//   First strobe occurs DIV cycles after IDLE->RUN.
//   DIV=1: sample_en is high on every busy cycle.
//  Accumulate, on each strobe edge: {carry,acc} <= acc + fcw_act (mod 2^ACC_W).
//   phase and wrap update on the same edge that raises sample_en (zero added latency).
//   wrap = carry.
//  fcw_act is loaded from fcw in three cases:
//   - on IDLE->RUN;
//   - on every strobe with carry=1;
//   - on every strobe while fcw_act==0, so the block cannot stall at zero.
//   fcw changes at any other time are ignored until one of these events.
//  FSM (states in sine_pkg):
//   IDLE: run=1 -> RUN; acc<=0, fcw_act<=fcw, count<=0.
//   RUN:  run=0 -> STOP. Accumulation continues unchanged.
//   STOP: run=1 before wrap -> RUN, with acc not cleared.
//         Strobe with carry=1 -> IDLE; acc<=0, phase=0.
//         Strobe with fcw_act==0 -> IDLE; acc<=0.
//  Simultaneous events:
//   - run falling on a carry strobe: RUN->STOP and the carry are handled in the same
//     cycle; STOP exits on the next carry, giving one full extra period.
//   - run rising on the exit strobe: STOP wins the edge and goes to IDLE; RUN is
//     re-entered on the next cycle.
//  Reset mid-operation: immediate return to reset values; no partial strobe.
//  Width rules: fcw zero-extended to ACC_W; all arithmetic unsigned; carry is discarded
//   after generating wrap.
// STRUCTURE
//  sine_pkg (shared): state enum {IDLE,RUN,STOP}; default DIV, FCW_W, ACC_W, PHASE_W.
//  Sub-module sine_tick_gen: DIV counter with enable, clear and registered tick output.
//  This block holds the FSM, accumulator and fcw_act register.
// TESTING
//  1. Reset: assert ResetN=0 mid-run -> outputs are 0 in the same cycle; busy=0.
//  2. DIV=4, fcw=64, run=1 -> sample_en every 4 cycles; phase = 1,2,3,...
//     1024th strobe: wrap=1, phase=0.
//  3. Frequency change: fcw 64->128 at strobe 10 -> step stays 1 until the wrap,
//     then becomes 2 (phase = 2,4,...).
//  4. Stop: run=0 at phase=300 -> strobes continue until carry; then phase=0,
//     busy=0, no further sample_en.
//  5. Stop then resume: run 0->1 at phase=500 during STOP -> continues 501,...
//     with no reset to 0.
//  6. fcw=0 at start, then set to 32 -> phase holds 0; next strobe loads 32;
//     phase steps by 0.5 (acc+=32, phase increments every 2 strobes).
//     Also fcw=0 in STOP -> IDLE on the next strobe.

Source files
------------

// File: rtl/sine_pkg.sv
// Shared types and default sizing for the sine generator phase path.
package sine_pkg;

  // Default Clk cycles per sample strobe (50 MHz system clock -> 1 MHz samples).
  localparam int DEF_DIV     = 50;
  localparam int DEF_FCW_W   = 8;
  localparam int DEF_ACC_W   = 16;
  localparam int DEF_PHASE_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage

// File: rtl/sine_tick_gen.sv
// Sample-rate divider: counts 0..DIV-1 while enabled and raises a registered
// one-cycle tick after the terminal count. tick_pre is the same condition one
// cycle early, so the consumer can update its registers on the edge that raises tick.
module sine_tick_gen
  import sine_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic Clk,
  input  logic ResetN,
  input  logic en,
  input  logic clr,
  output logic tick_pre,
  output logic tick
);

  // A one-bit counter is kept for DIV=1 so the terminal count is always hit.
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick_pre = en && (count == CNT_MAX);

  // Divider counter and registered tick; count is parked at 0 when cleared.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= tick_pre;
      if (clr) begin
        count <= '0;
      end else if (en) begin
        if (count == CNT_MAX) count <= '0;
        else                  count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sine_phase_nco.sv
// Phase source for the sine generator. Produces a one-cycle sample strobe every
// DIV Clk cycles and advances a phase accumulator by the active frequency word
// on each strobe. New frequency words only take effect at a phase wrap (or while
// the active word is zero), and a stop request always finishes the current period.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | no strobes, acc and phase parked at 0, waiting for run
//  RUN   | strobing and accumulating
//  STOP  | still accumulating; returns to IDLE at the next carry (or
//        | on a strobe with a zero active word), back to RUN if run returns
module sine_phase_nco
  import sine_pkg::*;
#(
  parameter int DIV     = DEF_DIV,
  parameter int FCW_W   = DEF_FCW_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int PHASE_W = DEF_PHASE_W
) (
  input  logic               Clk,
  input  logic               ResetN,
  input  logic               run,
  input  logic [FCW_W-1:0]   fcw,
  output logic [PHASE_W-1:0] phase,
  output logic               sample_en,
  output logic               wrap,
  output logic               busy
);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [FCW_W-1:0]   fcw_act;
  logic [ACC_W:0]     sum;
  logic               carry;
  logic               fcw_zero;
  logic               strobe;

  // Zero-extended add with the carry kept as the top bit.
  assign sum      = {1'b0, acc} + {{(ACC_W + 1 - FCW_W){1'b0}}, fcw_act};
  assign carry    = sum[ACC_W];
  assign fcw_zero = (fcw_act == '0);

  sine_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .Clk      (Clk),
    .ResetN   (ResetN),
    .en       (state != IDLE),
    .clr      (state == IDLE),
    .tick_pre (strobe),
    .tick     (sample_en)
  );

  // Sequencer, accumulator and active-word register; phase/wrap land on the
  // same edge that raises sample_en. Exit to IDLE takes priority over run.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state   <= IDLE;
      acc     <= '0;
      fcw_act <= '0;
      phase   <= '0;
      wrap    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (strobe) begin
        acc   <= sum[ACC_W-1:0];
        phase <= sum[ACC_W-1 -: PHASE_W];
        wrap  <= carry;
        if (carry || fcw_zero) fcw_act <= fcw;
      end
      case (state)
        IDLE: begin
          if (run) begin
            state   <= RUN;
            busy    <= 1'b1;
            acc     <= '0;
            phase   <= '0;
            fcw_act <= fcw;
          end
        end
        RUN: begin
          if (!run) state <= STOP;
        end
        STOP: begin
          if (strobe && (carry || fcw_zero)) begin
            state <= IDLE;
            busy  <= 1'b0;
            acc   <= '0;
            phase <= '0;
          end else if (run) begin
            state <= RUN;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
